// File: rtl/bf_pkg.sv
// Shared types and defaults for the beamformer scan sequencer.
package bf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } bf_state_t;

  localparam int COORD_W_DEF = 16;
  localparam int IDX_W_DEF   = 8;

  // Linear pixel address must hold (2^IDX_W-1)^2 - 1.
  function automatic int pix_addr_w(input int idx_w);
    return 2 * idx_w;
  endfunction

endpackage

// File: rtl/bf_focal_gen.sv
// Grid walker: ix/iz indices, focal coordinate accumulators, linear address, last flag.
module bf_focal_gen
  import bf_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int ADDR_W  = pix_addr_w(IDX_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] cfg_x0,
  input  logic [COORD_W-1:0] cfg_dx,
  input  logic [COORD_W-1:0] cfg_z0,
  input  logic [COORD_W-1:0] cfg_dz,
  input  logic [IDX_W-1:0]   cfg_nx,
  input  logic [IDX_W-1:0]   cfg_nz,
  output logic [COORD_W-1:0] x_f,
  output logic [COORD_W-1:0] z_f,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  logic [COORD_W-1:0] z0_q, dx_q, dz_q;
  logic [IDX_W-1:0]   nx_q, nz_q, ix, iz;
  logic               iz_wrap;

  assign iz_wrap = (iz == nz_q - IDX_W'(1));
  assign last    = iz_wrap && (ix == nx_q - IDX_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      z0_q <= '0;
      dx_q <= '0;
      dz_q <= '0;
      nx_q <= '0;
      nz_q <= '0;
      ix   <= '0;
      iz   <= '0;
      x_f  <= '0;
      z_f  <= '0;
      addr <= '0;
    end else if (load) begin
      z0_q <= cfg_z0;
      dx_q <= cfg_dx;
      dz_q <= cfg_dz;
      nx_q <= cfg_nx;
      nz_q <= cfg_nz;
      ix   <= '0;
      iz   <= '0;
      x_f  <= cfg_x0;
      z_f  <= cfg_z0;
      addr <= '0;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      // Depth is the inner axis; end of a line reloads z and moves x.
      if (iz_wrap) begin
        iz  <= '0;
        z_f <= z0_q;
        ix  <= ix + IDX_W'(1);
        x_f <= x_f + dx_q;
      end else begin
        iz  <= iz + IDX_W'(1);
        z_f <= z_f + dz_q;
      end
    end
  end

endmodule

// File: rtl/bf_scan_sequencer.sv
// Frame scheduler: walks the focal grid, sequences datapath clear/start/wait, emits pixels.
module bf_scan_sequencer
  import bf_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEF,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int SUM_WIDTH  = 20,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_start,
  input  logic                           abort,
  input  logic [COORD_W-1:0]             cfg_x0,
  input  logic [COORD_W-1:0]             cfg_dx,
  input  logic [COORD_W-1:0]             cfg_z0,
  input  logic [COORD_W-1:0]             cfg_dz,
  input  logic [IDX_W-1:0]               cfg_nx,
  input  logic [IDX_W-1:0]               cfg_nz,
  output logic                           bf_reset,
  output logic                           bf_start,
  output logic [COORD_W-1:0]             bf_x_f,
  output logic [COORD_W-1:0]             bf_z_f,
  input  logic                           bf_valid,
  input  logic [SUM_WIDTH-1:0]           bf_result,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [SUM_WIDTH-1:0]           pix_data,
  output logic [pix_addr_w(IDX_W)-1:0]   pix_addr,
  output logic                           pix_last,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           timeout_err
);

  localparam int ADDR_W = pix_addr_w(IDX_W);
  localparam int CLR_W  = $clog2(CLR_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT);

  bf_state_t   state, state_n;
  logic [CLR_W-1:0] clr_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic load, step, last, cap_result, cap_timeout, abort_run;

  bf_focal_gen #(
    .COORD_W (COORD_W),
    .IDX_W   (IDX_W),
    .ADDR_W  (ADDR_W)
  ) u_focal (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .cfg_x0 (cfg_x0),
    .cfg_dx (cfg_dx),
    .cfg_z0 (cfg_z0),
    .cfg_dz (cfg_dz),
    .cfg_nx (cfg_nx),
    .cfg_nz (cfg_nz),
    .x_f    (bf_x_f),
    .z_f    (bf_z_f),
    .addr   (pix_addr),
    .last   (last)
  );

  assign abort_run = abort && (state != S_IDLE);

  always_comb begin
    state_n     = state;
    load        = 1'b0;
    step        = 1'b0;
    cap_result  = 1'b0;
    cap_timeout = 1'b0;
    if (abort_run) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:
          // abort in the same cycle suppresses the frame entirely
          if (frame_start && !abort) begin
            load    = 1'b1;
            state_n = (cfg_nx == '0 || cfg_nz == '0) ? S_DONE : S_CLEAR;
          end
        S_CLEAR:
          if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_n = S_ISSUE;
        S_ISSUE:
          state_n = S_WAIT;
        S_WAIT:
          if (bf_valid) begin
            cap_result = 1'b1;
            state_n    = S_EMIT;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            cap_timeout = 1'b1;
            state_n     = S_EMIT;
          end
        S_EMIT:
          if (pix_ready) begin
            if (last) begin
              state_n = S_DONE;
            end else begin
              step    = 1'b1;
              state_n = S_CLEAR;
            end
          end
        S_DONE:
          state_n = S_IDLE;
        default:
          state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      clr_cnt     <= '0;
      to_cnt      <= '0;
      bf_reset    <= 1'b1;
      bf_start    <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_last    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_n;
      clr_cnt    <= (state == S_CLEAR && state_n == S_CLEAR) ? clr_cnt + CLR_W'(1) : '0;
      to_cnt     <= (state == S_WAIT && state_n == S_WAIT) ? to_cnt + TO_W'(1) : '0;
      // Outputs decode the next state so they line up with the state register.
      bf_reset   <= (state_n == S_CLEAR) || abort_run;
      bf_start   <= (state_n == S_ISSUE);
      pix_valid  <= (state_n == S_EMIT);
      pix_last   <= (state_n == S_EMIT) && last;
      busy       <= (state_n != S_IDLE);
      frame_done <= (state_n == S_DONE);
      if (cap_result)       pix_data <= bf_result;
      else if (cap_timeout) pix_data <= '0;
      if (load)             timeout_err <= 1'b0;
      else if (cap_timeout) timeout_err <= 1'b1;
    end
  end

endmodule
